invsqrt_newton_iter: RTL and testbench

Floating-point Newton–Raphson refinement stage of the inverse-square-root datapath, fed directly by the init stage's registered `x2` and `y` outputs. It iterates `y ← y·(1.5 − x2·y²)` a configurable number of times and emits the refined `y` with a one-cycle `ready` pulse. Operands are 31-bit sign-less floats: `[30:23]` holds the biased exponent (bias 127) and `[22:0]` holds the mantissa. It uses one shared multiplier and a 4-state-per-iteration FSM.

---
 rtl/invsqrt_pkg.sv | 33 +++
 rtl/invsqrt_newton_iter_fp_mul31.sv | 68 ++++++
 rtl/invsqrt_newton_iter.sv | 186 ++++++++++++++++++
 tb/tb_invsqrt_newton_iter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/invsqrt_pkg.sv
// Shared types and constants for the inverse-square-root Newton stage.
//
// Build option: define INVSQRT_ROUND_EN to make the multiplier and the
// 1.5 - p renormalisation round to nearest-even. Without it both paths
// truncate. Latency is the same either way.
//
// Float format (fp31_t): [30:23] biased exponent (bias 127), [22:0]
// mantissa with an implicit leading one. There is no sign bit.
package invsqrt_pkg;

  localparam int          EXP_BIAS       = 127;
  localparam logic [25:0] THREE_HALVES_Q = 26'h1800000;  // 1.5 in Q2.24
  localparam logic [30:0] FP_INF31       = 31'h7F800000;
  localparam logic [30:0] FP_ONE31       = 31'h3F800000;

`ifdef INVSQRT_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  typedef logic [30:0] fp31_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ,
    S_MX,
    S_SUB,
    S_MY,
    S_DONE
  } state_t;

endpackage

// File: rtl/invsqrt_newton_iter_fp_mul31.sv
// fp_mul31: combinational multiplier for sign-less 31-bit floats.
//
// Ports:
//   a, b  : operands (fp31_t)
//   p     : product (fp31_t); 0 on underflow or zero operand, FP_INF31 on
//           overflow
//   err   : high when the product is not a normal in-range float
//
// Rounding follows INVSQRT_ROUND_EN (see invsqrt_pkg); it is truncation
// when that macro is not defined.
module fp_mul31
  import invsqrt_pkg::*;
(
  input  fp31_t a,
  input  fp31_t b,
  output fp31_t p,
  output logic  err
);

  // Returns {carry, frac}. The carry means the mantissa rolled over to 2.0
  // and the exponent has to move up by one.
  function automatic logic [23:0] round_frac(input logic [22:0] frac,
                                             input logic        guard,
                                             input logic        sticky);
    logic inc;
    inc = ROUND_EN & guard & (sticky | frac[0]);
    return {1'b0, frac} + {23'b0, inc};
  endfunction

  logic [23:0]        ma;
  logic [23:0]        mb;
  logic [47:0]        prod;
  logic               norm;
  logic [22:0]        frac_t;
  logic               guard;
  logic               sticky;
  logic [23:0]        rnd;
  logic signed [10:0] exp_s;
  logic               zero_op;

  assign ma      = {1'b1, a[22:0]};
  assign mb      = {1'b1, b[22:0]};
  assign prod    = {24'b0, ma} * {24'b0, mb};
  // The product of two [1,2) mantissas lies in [1,4): at most one shift.
  assign norm    = prod[47];
  assign frac_t  = norm ? prod[46:24] : prod[45:23];
  assign guard   = norm ? prod[23] : prod[22];
  assign sticky  = norm ? (|prod[22:0]) : (|prod[21:0]);
  assign rnd     = round_frac(frac_t, guard, sticky);
  assign zero_op = (a[30:23] == 8'd0) || (b[30:23] == 8'd0);

  assign exp_s = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]})
               + $signed({10'b0, norm}) + $signed({10'b0, rnd[23]})
               - 11'sd127;

  always_comb begin
    p   = {exp_s[7:0], rnd[22:0]};
    err = 1'b0;
    if (zero_op || (exp_s < 11'sd1)) begin
      p   = '0;
      err = 1'b1;
    end else if (exp_s > 11'sd254) begin
      p   = FP_INF31;
      err = 1'b1;
    end
  end

endmodule

// File: rtl/invsqrt_newton_iter.sv
// invsqrt_newton_iter: Newton-Raphson refinement y <- y*(1.5 - x2*y^2)
// for the inverse-square-root datapath, repeated ITER times (1..3) with a
// single shared fp_mul31.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   valid     : one-cycle sample strobe; x2, y, error_in qualify with it
//   x2        : half the input number (fp31_t)
//   y         : initial guess y0 (fp31_t)
//   error_in  : upstream error for this sample
//   y_out     : refined y, forced to 0 on error; held until the next result
//   ready     : one-cycle pulse marking y_out / error_out as new
//   error_out : sample error (upstream or raised here)
//   busy      : a sample is in flight (including the result cycle)
//   overrun   : valid arrived while busy; that sample is dropped
//
// Build option: INVSQRT_ROUND_EN selects round-to-nearest-even in the
// multiplier and in the 1.5 - p renormalisation; default is truncation.
module invsqrt_newton_iter
  import invsqrt_pkg::*;
#(
  parameter int ITER = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  valid,
  input  fp31_t x2,
  input  fp31_t y,
  input  logic  error_in,
  output fp31_t y_out,
  output logic  ready,
  output logic  error_out,
  output logic  busy,
  output logic  overrun
);

  localparam logic [1:0] LAST = 2'(ITER - 1);

  // Returns {carry, frac}; see fp_mul31 for the same scheme.
  function automatic logic [23:0] round_frac(input logic [22:0] frac,
                                             input logic        guard,
                                             input logic        sticky);
    logic inc;
    inc = ROUND_EN & guard & (sticky | frac[0]);
    return {1'b0, frac} + {23'b0, inc};
  endfunction

  state_t     state;
  state_t     state_nx;
  logic [1:0] cnt;
  logic       err;
  fp31_t      xr;
  fp31_t      yr;
  fp31_t      p;
  fp31_t      t;

  fp31_t      mul_a;
  fp31_t      mul_b;
  fp31_t      mul_p;
  logic       mul_err;

  fp31_t      t_nx;
  logic       t_err;
  logic [24:0] p_q;
  logic [24:0] t_q;
  logic [23:0] t_rnd;

  // Shared multiplier, operands selected by the current step
  always_comb begin
    mul_a = yr;
    mul_b = t;
    case (state)
      S_SQ: begin
        mul_a = yr;
        mul_b = yr;
      end
      S_MX: begin
        mul_a = xr;
        mul_b = p;
      end
      default: begin
        mul_a = yr;
        mul_b = t;
      end
    endcase
  end

  fp_mul31 u_mul (
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p),
    .err (mul_err)
  );

  // t = 1.5 - p in Q2.24. p is expected in [0.25, 1), so only exponents
  // 126 (mantissa as-is) and 125 (shifted right once) are converted; the
  // difference then lies in (0.5, 1.25] with its leading one at bit 24 or 23.
  always_comb begin
    p_q   = (p[30:23] == 8'd126) ? {1'b0, 1'b1, p[22:0]}
                                 : {2'b0, 1'b1, p[22:1]};
    t_q   = 25'(THREE_HALVES_Q - {1'b0, p_q});
    t_rnd = t_q[24] ? round_frac(t_q[23:1], t_q[0], 1'b0)
                    : round_frac(t_q[22:0], 1'b0, 1'b0);
    t_nx  = {(t_q[24] ? 8'd127 : 8'd126) + {7'b0, t_rnd[23]}, t_rnd[22:0]};
    t_err = 1'b0;
    if ((p[30:23] != 8'd125) && (p[30:23] != 8'd126)) begin
      t_nx  = FP_ONE31;
      t_err = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = valid ? S_SQ : S_IDLE;
      S_SQ:    state_nx = S_MX;
      S_MX:    state_nx = S_SUB;
      S_SUB:   state_nx = S_MY;
      S_MY:    state_nx = (cnt == LAST) ? S_DONE : S_SQ;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready   = (state == S_DONE);
    busy    = (state != S_IDLE);
    overrun = valid & busy & ~rst;
  end

  // Control: iteration counter, sticky error, registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      err       <= 1'b0;
      y_out     <= '0;
      error_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid) begin
            cnt <= '0;
            err <= error_in;
          end
        end
        S_SQ, S_MX: err <= err | mul_err;
        S_SUB:      err <= err | t_err;
        S_MY: begin
          err <= err | mul_err;
          if (cnt == LAST) begin
            y_out     <= (err | mul_err) ? '0 : mul_p;
            error_out <= err | mul_err;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers, loaded per step
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (valid) begin
          xr <= x2;
          yr <= y;
        end
      end
      S_SQ, S_MX: p <= mul_p;
      S_SUB:      t <= t_nx;
      S_MY:       yr <= mul_p;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_invsqrt_newton_iter.sv
module tb_invsqrt_newton_iter;
  import invsqrt_pkg::*;

  localparam int ITER = 2;
  localparam int LAT  = 4 * ITER + 1;

  logic  clk = 1'b0;
  logic  rst;
  logic  valid;
  fp31_t x2;
  fp31_t y;
  logic  error_in;
  fp31_t y_out;
  logic  ready;
  logic  error_out;
  logic  busy;
  logic  overrun;

  int checks    = 0;
  int errors    = 0;
  int ready_cnt = 0;
  int ovr_cnt   = 0;

  always #5 clk = ~clk;

  invsqrt_newton_iter #(.ITER(ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .x2        (x2),
    .y         (y),
    .error_in  (error_in),
    .y_out     (y_out),
    .ready     (ready),
    .error_out (error_out),
    .busy      (busy),
    .overrun   (overrun)
  );

  always @(negedge clk) begin
    if (ready)   ready_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference float multiply: exact integer product, then normalise,
  // optional round-to-nearest-even, range checks.
  function automatic logic [31:0] m_mul(input fp31_t a, input fp31_t b);
    int     ea, eb, e, sh;
    longint prod, mant, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return {1'b1, 31'd0};
    prod = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    e = ea + eb - EXP_BIAS;
    if (prod >= (longint'(1) << 47)) begin sh = 24; e++; end
    else sh = 23;
    mant = prod >> sh;
    rem  = prod - (mant << sh);
    half = longint'(1) << (sh - 1);
    if (ROUND_EN && (rem > half || (rem == half && (mant % 2) == 1))) mant++;
    if (mant == (longint'(1) << 24)) begin mant = mant >> 1; e++; end
    if (e < 1)   return {1'b1, 31'd0};
    if (e > 254) return {1'b1, FP_INF31};
    return {1'b0, 8'(e), 23'(mant)};
  endfunction

  // Reference 1.5 - p via Q2.24 integer arithmetic.
  function automatic logic [31:0] m_sub(input fp31_t pv);
    int     e, te;
    longint pq, tq, m;
    e = int'(pv[30:23]);
    if (e < 125 || e > 126) return {1'b1, 31'h3F800000};
    pq = (longint'({1'b1, pv[22:0]}) * 2) >> (127 - e);
    tq = longint'(32'h1800000) - pq;
    if (tq >= (longint'(1) << 24)) begin
      te = 127;
      m  = tq >> 1;
      if (ROUND_EN && (tq % 2) == 1 && (m % 2) == 1) m++;
    end else begin
      te = 126;
      m  = tq;
    end
    if (m == (longint'(1) << 24)) begin m = m >> 1; te++; end
    return {1'b0, 8'(te), 23'(m)};
  endfunction

  task automatic model(input fp31_t xv, input fp31_t yv, input bit ev,
                       output fp31_t yo, output bit eo);
    logic [31:0] r;
    fp31_t yy, pp, tt;
    bit    e;
    e  = ev;
    yy = yv;
    for (int k = 0; k < ITER; k++) begin
      r = m_mul(yy, yy); e |= r[31]; pp = r[30:0];
      r = m_mul(xv, pp); e |= r[31]; pp = r[30:0];
      r = m_sub(pp);     e |= r[31]; tt = r[30:0];
      r = m_mul(yy, tt); e |= r[31]; yy = r[30:0];
    end
    eo = e;
    yo = e ? 31'd0 : yy;
  endtask

  function automatic real to_real(input fp31_t f);
    if (f[30:23] == 8'd0) return 0.0;
    return (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (real'(int'(f[30:23])) - 127.0));
  endfunction

  function automatic real newton_ref(input fp31_t xv, input fp31_t yv);
    real xr, yr;
    xr = to_real(xv);
    yr = to_real(yv);
    for (int k = 0; k < ITER; k++) yr = yr * (1.5 - xr * yr * yr);
    return yr;
  endfunction

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  task automatic gen(output fp31_t xv, output fp31_t yv, output bit ev);
    int ex, ey;
    ex = $urandom_range(100, 152);
    ey = 127 + (126 - ex) / 2;
    xv = {8'(ex), 23'($urandom)};
    yv = {8'(ey), 23'($urandom)};
    ev = ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 9) == 0) yv[30:23] = 8'd0;
  endtask

  // Drive one sample in the current cycle, wait for ready, check it.
  // Returns in the result cycle.
  task automatic run_check(input string tag, input fp31_t xv, input fp31_t yv,
                           input bit ev, output fp31_t yo);
    fp31_t ye;
    bit    ee;
    int    lat;
    model(xv, yv, ev, ye, ee);
    valid = 1'b1; x2 = xv; y = yv; error_in = ev;
    tick;
    valid = 1'b0;
    lat = 1;
    while (!ready && lat < 64) begin tick; lat++; end
    check({tag, " latency"}, 32'(lat), 32'(LAT));
    check({tag, " y_out"}, {1'b0, y_out}, {1'b0, ye});
    check({tag, " error_out"}, {31'd0, error_out}, {31'd0, ee});
    yo = y_out;
  endtask

  initial begin
    fp31_t xv, yv, yo, ye;
    bit    ev, ee;
    int    rc0, oc0, lat;

    rst = 1'b1; valid = 1'b0; x2 = '0; y = '0; error_in = 1'b0;
    tick; tick;
    check("rst y_out", {1'b0, y_out}, 32'd0);
    check("rst ready", {31'd0, ready}, 32'd0);
    check("rst error_out", {31'd0, error_out}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    tick;

    // number 4.0
    run_check("num4", 31'h40000000, 31'h3EF759DF, 1'b0, yo);
    check("num4 approx", {31'd0, absr(to_real(yo) - newton_ref(31'h40000000, 31'h3EF759DF)) < 1e-4}, 32'd1);
    tick;

    // number 1.0, two iterations converge near 1
    run_check("num1", 31'h3F000000, 31'h3F7759DF, 1'b0, yo);
    check("num1 approx", {31'd0, absr(to_real(yo) - 1.0) < 1e-5}, 32'd1);
    tick;

    // upstream error keeps latency, zero result
    run_check("err_in", 31'h40000000, 31'h3EF759DF, 1'b1, yo);
    check("err_in zero", {1'b0, yo}, 32'd0);
    check("err_in flag", {31'd0, error_out}, 32'd1);
    tick;

    // overrun: second valid 2 cycles later, and another one in the DONE cycle
    rc0 = ready_cnt; oc0 = ovr_cnt;
    model(31'h3F000000, 31'h3F7759DF, 1'b0, ye, ee);
    valid = 1'b1; x2 = 31'h3F000000; y = 31'h3F7759DF; error_in = 1'b0;
    tick;
    valid = 1'b0;
    tick;
    valid = 1'b1; x2 = 31'h40000000; y = 31'h3EF759DF; error_in = 1'b1;
    #1;
    check("ovr pulse", {31'd0, overrun}, 32'd1);
    tick;
    valid = 1'b0;
    lat = 3;
    while (!ready && lat < 64) begin tick; lat++; end
    check("ovr latency", 32'(lat), 32'(LAT));
    check("ovr y_out", {1'b0, y_out}, {1'b0, ye});
    check("ovr error_out", {31'd0, error_out}, {31'd0, ee});
    valid = 1'b1;
    #1;
    check("done ovr pulse", {31'd0, overrun}, 32'd1);
    tick;
    valid = 1'b0;
    check("done drop idle", {31'd0, busy}, 32'd0);
    repeat (LAT + 3) tick;
    check("ovr ready count", 32'(ready_cnt - rc0), 32'd1);
    check("ovr pulse count", 32'(ovr_cnt - oc0), 32'd2);
    check("ovr hold y_out", {1'b0, y_out}, {1'b0, ye});

    // back-to-back at minimum spacing
    oc0 = ovr_cnt; rc0 = ready_cnt;
    for (int i = 0; i < 6; i++) begin
      gen(xv, yv, ev);
      run_check($sformatf("b2b%0d", i), xv, yv, ev, yo);
      tick;
    end
    check("b2b no overrun", 32'(ovr_cnt - oc0), 32'd0);
    check("b2b ready count", 32'(ready_cnt - rc0), 32'd6);

    // reset mid-flight; y_out beforehand is the nonzero num1-style result
    run_check("pre_rst", 31'h3F000000, 31'h3F7759DF, 1'b0, yo);
    tick;
    rc0 = ready_cnt;
    valid = 1'b1; x2 = 31'h40000000; y = 31'h3EF759DF; error_in = 1'b1;
    tick;
    valid = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst y_out", {1'b0, y_out}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst ready", {31'd0, ready}, 32'd0);
    check("midrst error_out", {31'd0, error_out}, 32'd0);
    run_check("postrst", 31'h40000000, 31'h3EF759DF, 1'b0, yo);
    tick;
    check("midrst ready count", 32'(ready_cnt - rc0), 32'd1);

    // randomized samples with idle gaps
    for (int i = 0; i < 30; i++) begin
      gen(xv, yv, ev);
      repeat ($urandom_range(0, 3)) tick;
      run_check($sformatf("rnd%0d", i), xv, yv, ev, yo);
      tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
